// File: rtl/arb_requester.sv
// rtl/arb_requester.sv - arbiter client endpoint: command FIFO, request/grant FSM, optional starvation monitor
// Optional starvation monitor built only when ARB_REQ_STARVE_MON_EN is defined.
module arb_requester #(
    parameter int DEPTH    = 4,
    parameter int LEN_W    = 4,
    parameter int STARVE_K = 50,
    parameter int WAIT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    input  logic [LEN_W-1:0]         cmd_len,
    output logic                     cmd_ready,
    output logic                     req,
    input  logic                     grant,
    output logic                     beat,
    output logic                     beat_last,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     grant_err,
    output logic [WAIT_W-1:0]        wait_cnt,
    output logic                     starve
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [LEN_W-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              done_q, done_d;
    logic              grant_err_q, grant_err_d;
    logic              push, pop, full;
    logic [LEN_W-1:0]  head_len, next_len;

    function automatic logic [LEN_W-1:0] fix_len(input logic [LEN_W-1:0] l);
        return (l == '0) ? LEN_W'(1) : l;
    endfunction

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign req       = (state_q != IDLE);
    assign beat      = grant && req;
    assign beat_last = beat && (rem_q == LEN_W'(1));
    assign pop       = beat_last;
    assign done      = done_q;
    assign pending   = count_q;
    assign grant_err = grant_err_q;
    assign head_len  = mem[rd_ptr_q];
    assign next_len  = mem[rd_ptr_q + AW'(1)];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        done_d      = pop;
        grant_err_d = grant_err_q | (grant && state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = REQ;
                    rem_d   = fix_len(head_len);
                end
            end
            REQ, XFER: begin
                if (grant) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        // Chain straight into the next burst so req never dips
                        if (count_q > (AW+1)'(1)) begin
                            state_d = REQ;
                            rem_d   = fix_len(next_len);
                        end else if (push) begin
                            state_d = REQ;
                            rem_d   = fix_len(cmd_len);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = XFER;
                    end
                end else if (state_q == XFER) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= cmd_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            done_q      <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            done_q      <= done_d;
            grant_err_q <= grant_err_d;
        end
    end

`ifdef ARB_REQ_STARVE_MON_EN
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (beat)
            wait_cnt_d = '0;
        else if (req && !grant && wait_cnt_q != '1)
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wait_cnt_q <= '0;
        else        wait_cnt_q <= wait_cnt_d;
    end

    assign wait_cnt = wait_cnt_q;
    assign starve   = (32'(wait_cnt_q) >= STARVE_K);
`else
    assign wait_cnt = '0;
    assign starve   = 1'b0;
`endif
endmodule

// File: doc/arb_requester.md
# arb_requester

Client-side endpoint of the arbiter request/grant interface; one instance per requester port. Queues transfer commands, each a burst length in beats. Drives `req` and issues one beat per cycle while `grant` is held. Re-requests the remainder when the arbiter withdraws grant mid-burst, for example at grant-hold expiry. Optionally monitors its own starvation against a fixed bound.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2
- `LEN_W`, 4: width of burst length field
- `STARVE_K`, 50: starvation threshold in wait cycles
- `WAIT_W`, 8: wait counter width; `2**WAIT_W-1 ≥ STARVE_K`

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command offered
- `cmd_len` in LEN_W: burst length in beats; 0 is treated as 1
- `cmd_ready` out 1: FIFO not full
- `req` out 1: registered request to arbiter
- `grant` in 1: grant from arbiter for this port
- `beat` out 1: one beat transferred this cycle
- `beat_last` out 1: current beat is last of burst
- `done` out 1: one-cycle pulse, cycle after last beat
- `pending` out $clog2(DEPTH)+1: FIFO occupancy
- `grant_err` out 1: sticky; grant seen while `req`=0
- `wait_cnt` out WAIT_W: current wait run length
- `starve` out 1: `wait_cnt` ≥ STARVE_K

## Operation
- Push on `cmd_valid && cmd_ready`. `cmd_ready = !full`. Full blocks push even if a pop occurs the same cycle.
- Pop of the FIFO head occurs on the cycle of the last beat.
- FSM states are IDLE, REQ and XFER. `req`=1 in REQ and XFER, 0 in IDLE.
- IDLE → REQ when FIFO non-empty. Load `rem` = head length, with 0 mapped to 1.
- REQ: `grant`=1 issues a beat and decrements `rem`.
  - If that beat was the last, apply the post-burst rule below.
  - Otherwise go to XFER.
- XFER: `grant`=1 issues a beat and decrements `rem`.
  - `grant`=0 returns to REQ, keeping `rem`. Retained partial progress is never re-sent.
- Post-burst rule, applied on the last beat:
  - Pop the FIFO and pulse `done` next cycle.
  - If the FIFO still holds entries after the pop, load the new head and go to REQ. `req` stays high with no gap.
  - Otherwise go to IDLE.
- `beat = grant && (state==REQ || state==XFER)`, combinational.
- `beat_last = beat && rem==1`.
- Grant while in IDLE produces no beat and sets `grant_err`. `grant_err` clears only on reset.
- Push and pop in the same cycle leaves `pending` unchanged. The FIFO wraps its pointers modulo DEPTH.
- `wait_cnt`:
  - Increments on cycles with `req`=1 and `grant`=0.
  - Saturates at `2**WAIT_W-1`.
  - Clears on any beat.
  - Holds in IDLE.
- Reset mid-burst discards all queued commands and the remaining count. No `done` is issued for the aborted burst.

## Timing
- Reset values:
  - `req`, `beat`, `beat_last`, `done`, `grant_err`, `wait_cnt`, `starve` = 0
  - `pending` = 0
  - `cmd_ready` = 1
- Command accepted in cycle N with FSM idle: `req` first high in cycle N+2.
- Beat latency from grant is zero cycles. The beat occurs in the same cycle `grant` is sampled high.
- `done` is high in cycle M+1 for a last beat in cycle M.
- Burst of L beats under continuous grant: L consecutive `beat` cycles.
- Last beat with an empty FIFO: `req` low in the following cycle.
- `starve` is combinational from registered `wait_cnt`. It rises in the cycle after the STARVE_K-th consecutive ungranted request cycle.

## Configuration
- `ARB_REQ_STARVE_MON_EN` defined: `wait_cnt` and `starve` behave as above.
- Not defined:
  - No wait counter is built.
  - `wait_cnt` tied to 0 and `starve` tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then push len=3; grant held high from the first `req` cycle → `req` at N+2; `beat` for 3 cycles; `beat_last` on the 3rd; `done` one cycle later; `req` drops.
- Push len=6; grant high 4 cycles, low 2, high again → 4 beats, `req` stays high through the gap, 2 further beats, a single `done`.
- Push 4 commands with no grant → `pending`=4, `cmd_ready`=0; a 5th `cmd_valid` is refused. Then grant continuously → bursts drain back-to-back with no `req` gap.
- With macro defined, hold `req` high and `grant` low for 50 cycles → `wait_cnt`=50 and `starve`=1. One granted beat → both return to 0.
- Assert `grant` while idle → no `beat`, `grant_err`=1 and remains 1 afterwards.
- Assert `rst_n` low mid-burst with `rem`=2 → all outputs at reset values, `pending`=0, no `done`.
